lsu: RTL

- Memory-access stage sitting directly upstream of the commit stage.
- Captures one instruction from the execute stage, performs at most one load or store over an AXI4-Lite-style data bus, and hands the result to commit.
- Uses the same valid/ready handshake on both sides.
- Single outstanding transaction; no pipelining inside the block.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_controller.sv | 80 ++++++++
 rtl/lsu.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memory op codes, FSM states,
// AXI response codes and the load-data formatting helper.
package lsu_pkg;

    localparam logic [2:0] MEM_LB  = 3'b000;
    localparam logic [2:0] MEM_LH  = 3'b001;
    localparam logic [2:0] MEM_LW  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b100;
    localparam logic [2:0] MEM_LHU = 3'b101;
    localparam logic [2:0] MEM_SB  = 3'b000;
    localparam logic [2:0] MEM_SH  = 3'b001;
    localparam logic [2:0] MEM_SW  = 3'b010;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_SLVERR = 2'b10;
    localparam logic [1:0] AXI_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } lsu_state_e;

    // Pick the byte/half addressed by off out of the bus word and extend it.
    function automatic logic [31:0] format_load(input logic [2:0] op,
                                                input logic [1:0] off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {off, 3'b000});
        h = 16'(word >> {off[1], 4'b0000});
        case (op)
            MEM_LB:  format_load = {{24{b[7]}}, b};
            MEM_LH:  format_load = {{16{h[15]}}, h};
            MEM_LBU: format_load = {24'd0, b};
            MEM_LHU: format_load = {16'd0, h};
            default: format_load = word;
        endcase
    endfunction

endpackage

// File: rtl/lsu_controller.sv
// LSU sequencing FSM: owns the pre/post handshakes, all AXI valid/ready
// outputs, and produces the capture and load-latch enables for the datapath.
module lsu_controller
    import lsu_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic valid_pre,
    input  logic mem_ren,
    input  logic mem_wen,
    input  logic misalign,
    input  logic arready,
    input  logic rvalid,
    input  logic awready,
    input  logic wready,
    input  logic bvalid,
    input  logic ready_post,
    output logic ready_pre,
    output logic valid_post,
    output logic arvalid,
    output logic rready,
    output logic awvalid,
    output logic wvalid,
    output logic bready,
    output logic capture,
    output logic rlatch
);

    lsu_state_e state_reg, state_next;
    logic       aw_done_reg, w_done_reg;
    logic       aw_ok, w_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                aw_done_reg <= 1'b0;
                w_done_reg  <= 1'b0;
            end else begin
                if (awvalid && awready) aw_done_reg <= 1'b1;
                if (wvalid && wready)   w_done_reg  <= 1'b1;
            end
        end
    end

    always_comb begin
        ready_pre  = (state_reg == ST_IDLE) && !reset;
        capture    = valid_pre && ready_pre;
        arvalid    = (state_reg == ST_AR);
        rready     = (state_reg == ST_R);
        awvalid    = (state_reg == ST_AW) && !aw_done_reg;
        wvalid     = (state_reg == ST_AW) && !w_done_reg;
        bready     = (state_reg == ST_B);
        valid_post = (state_reg == ST_DONE);
        rlatch     = (state_reg == ST_R) && rvalid;
        // The two write channels may complete in either order or together.
        aw_ok      = aw_done_reg || (awvalid && awready);
        w_ok       = w_done_reg  || (wvalid && wready);
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (capture) begin
                if (misalign)     state_next = ST_DONE;
                else if (mem_ren) state_next = ST_AR;
                else if (mem_wen) state_next = ST_AW;
                else              state_next = ST_DONE;
            end
            ST_AR:   if (arready) state_next = ST_R;
            ST_R:    if (rvalid) state_next = ST_DONE;
            ST_AW:   if (aw_ok && w_ok) state_next = ST_B;
            ST_B:    if (bvalid) state_next = ST_DONE;
            ST_DONE: if (ready_post) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit top: payload registers, store-data/strobe generation and
// load formatting. Define LSU_ALIGN_CHECK_EN to trap misaligned half/word accesses.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_pre_i,
    output logic              ready_pre_o,
    output logic              valid_post_o,
    input  logic              ready_post_i,
    input  logic [31:0]       pc_i,
    input  logic [31:0]       inst_i,
    input  logic              wsel_i,
    input  logic              wena_i,
    input  logic [4:0]        waddr_i,
    input  logic [31:0]       alu_result_i,
    input  logic              mem_ren_i,
    input  logic              mem_wen_i,
    input  logic [2:0]        mem_op_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic              csr_wena_i,
    input  logic [31:0]       csr_waddr_i,
    input  logic [31:0]       csr_wdata_i,
    output logic [31:0]       pc_o,
    output logic [31:0]       inst_o,
    output logic              wsel_o,
    output logic              wena_o,
    output logic [4:0]        waddr_o,
    output logic [31:0]       alu_result_o,
    output logic              csr_wena_o,
    output logic [31:0]       csr_waddr_o,
    output logic [31:0]       csr_wdata_o,
    output logic [31:0]       mem_result_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [3:0]        wstrb_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    input  logic [1:0]        bresp_i,
    input  logic              bvalid_i,
    output logic              bready_o
);

    logic              capture, rlatch, misalign;
    logic [31:0]       pc_reg, inst_reg, alu_result_reg, csr_waddr_reg, csr_wdata_reg;
    logic [31:0]       mem_result_reg;
    logic              wsel_reg, wena_reg, csr_wena_reg, misalign_reg;
    logic [4:0]        waddr_reg;
    logic [2:0]        mem_op_reg;
    logic [1:0]        off_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [3:0]        wstrb_reg, wstrb_next;

    // Responses are kept on the port list for a later trap path.
    logic unused_resp;
    assign unused_resp = ^{rresp_i, bresp_i};

`ifdef LSU_ALIGN_CHECK_EN
    assign misalign = (mem_ren_i || mem_wen_i) &&
                      (((mem_op_i[1:0] == 2'b01) && alu_result_i[0]) ||
                       ((mem_op_i[1:0] == 2'b10) && (alu_result_i[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        wdata_next = mem_wdata_i;
        wstrb_next = 4'hF;
        case (mem_op_i[1:0])
            2'b00: begin
                wdata_next = {4{mem_wdata_i[7:0]}};
                wstrb_next = 4'b0001 << alu_result_i[1:0];
            end
            2'b01: begin
                wdata_next = {2{mem_wdata_i[15:0]}};
                wstrb_next = 4'b0011 << alu_result_i[1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_reg         <= '0;
            inst_reg       <= '0;
            wsel_reg       <= 1'b0;
            wena_reg       <= 1'b0;
            waddr_reg      <= '0;
            alu_result_reg <= '0;
            csr_wena_reg   <= 1'b0;
            csr_waddr_reg  <= '0;
            csr_wdata_reg  <= '0;
            misalign_reg   <= 1'b0;
            mem_op_reg     <= '0;
            off_reg        <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            mem_result_reg <= '0;
        end else if (capture) begin
            pc_reg         <= pc_i;
            inst_reg       <= inst_i;
            wsel_reg       <= wsel_i;
            wena_reg       <= wena_i && !misalign;
            waddr_reg      <= waddr_i;
            alu_result_reg <= alu_result_i;
            csr_wena_reg   <= csr_wena_i;
            csr_waddr_reg  <= csr_waddr_i;
            csr_wdata_reg  <= csr_wdata_i;
            misalign_reg   <= misalign;
            mem_op_reg     <= mem_op_i;
            off_reg        <= alu_result_i[1:0];
            addr_reg       <= {alu_result_i[ADDR_W-1:2], 2'b00};
            wdata_reg      <= wdata_next;
            wstrb_reg      <= wstrb_next;
            mem_result_reg <= '0;
        end else if (rlatch) begin
            mem_result_reg <= format_load(mem_op_reg, off_reg, rdata_i);
        end
    end

    assign pc_o         = pc_reg;
    assign inst_o       = inst_reg;
    assign wsel_o       = wsel_reg;
    assign wena_o       = wena_reg;
    assign waddr_o      = waddr_reg;
    assign alu_result_o = alu_result_reg;
    assign csr_wena_o   = csr_wena_reg;
    assign csr_waddr_o  = csr_waddr_reg;
    assign csr_wdata_o  = csr_wdata_reg;
    assign mem_result_o = mem_result_reg;
    assign misalign_o   = misalign_reg;
    assign araddr_o     = addr_reg;
    assign awaddr_o     = addr_reg;
    assign wdata_o      = wdata_reg;
    assign wstrb_o      = wstrb_reg;

    lsu_controller u_ctrl (
        .clock      (clock),
        .reset      (reset),
        .valid_pre  (valid_pre_i),
        .mem_ren    (mem_ren_i),
        .mem_wen    (mem_wen_i),
        .misalign   (misalign),
        .arready    (arready_i),
        .rvalid     (rvalid_i),
        .awready    (awready_i),
        .wready     (wready_i),
        .bvalid     (bvalid_i),
        .ready_post (ready_post_i),
        .ready_pre  (ready_pre_o),
        .valid_post (valid_post_o),
        .arvalid    (arvalid_o),
        .rready     (rready_o),
        .awvalid    (awvalid_o),
        .wvalid     (wvalid_o),
        .bready     (bready_o),
        .capture    (capture),
        .rlatch     (rlatch)
    );

endmodule
